// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM.
//   ram_state_e     : clear-sequencer states (CLEAR, READY)
//   RDW_* constants : port A read-during-write selection
//   calc_num_bytes  : number of byte lanes in a word
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int calc_num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/ram_out_pipe.sv
// Optional output register stage for one RAM read port.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_data    : read result from the array stage
//   in_flag             : side-band bit travelling with the data (collision on port B)
//   out_valid/out_data  : delayed by STAGES (0 or 1) cycles
//   out_flag            : delayed side-band bit
// Data is only captured on valid, so out_data holds its last value between reads.
module ram_out_pipe
  import ram_pkg::*;
#(
  parameter int STAGES = 1,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_flag,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_flag
);

  generate
    if (STAGES == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign out_flag  = in_flag;
    end else begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_flag  <= 1'b0;
        end else begin
          out_valid <= in_valid;
          out_flag  <= in_flag;
          if (in_valid) out_data <= in_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ram_dual_port_be.sv
// Simple dual-port RAM: port A read/write with byte enables, port B read-only.
//   clk, rst          : clock, async active-high reset (array contents untouched)
//   a_en/a_we/a_addr/a_din : port A request; a_we == 0 is a plain read
//   a_dout/a_valid    : port A read data, valid 1+OUT_REG cycles after request
//   b_en/b_addr       : port B read request
//   b_dout/b_valid    : port B read data, valid 1+OUT_REG cycles after request
//   busy              : post-reset zero fill running; requests ignored
//   collision         : A wrote the address B read in that cycle; aligned with b_valid
module ram_dual_port_be
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int OUT_REG        = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NUM_BYTES     = calc_num_bytes(DATA_WIDTH, BYTE_WIDTH),
  localparam int DEPTH         = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic [NUM_BYTES-1:0]  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid,
  output logic                  busy,
  output logic                  collision
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ram_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_we;

  logic                  a_go, b_go, a_wr;
  logic [DATA_WIDTH-1:0] a_merged;

  logic                  a_vld_s1, b_vld_s1, coll_s1;
  logic [DATA_WIDTH-1:0] a_dat_s1, b_dat_s1;
  logic                  a_flag_unused;

  // Clear sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_cnt == '1) state_nxt = ST_READY;
      end
      default: begin
      end
    endcase
  end

  // Wraps back to 0 on the last clear write, ready for the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         clr_cnt <= '0;
    else if (clr_we) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
  end

  assign a_go = a_en & ~busy;
  assign b_go = b_en & ~busy;
  assign a_wr = a_go & (|a_we);

  // Post-write view of the addressed word, used for write-first reads.
  always_comb begin
    a_merged = mem[a_addr];
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (a_we[i]) a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Array: per-byte writes so byte-enable RAM macros can be inferred.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (a_wr) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (a_we[i]) mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Synchronous read stage. Port B always sees the pre-write word because the
  // array update above is non-blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_s1 <= 1'b0;
      b_vld_s1 <= 1'b0;
      coll_s1  <= 1'b0;
      a_dat_s1 <= '0;
      b_dat_s1 <= '0;
    end else begin
      a_vld_s1 <= a_go;
      b_vld_s1 <= b_go;
      coll_s1  <= a_wr & b_go & (a_addr == b_addr);
      if (a_go) a_dat_s1 <= (RDW_MODE == RDW_WRITE_FIRST) ? a_merged : mem[a_addr];
      if (b_go) b_dat_s1 <= mem[b_addr];
    end
  end

  ram_out_pipe #(
    .STAGES (OUT_REG),
    .WIDTH  (DATA_WIDTH)
  ) u_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_vld_s1),
    .in_data   (a_dat_s1),
    .in_flag   (1'b0),
    .out_valid (a_valid),
    .out_data  (a_dout),
    .out_flag  (a_flag_unused)
  );

  ram_out_pipe #(
    .STAGES (OUT_REG),
    .WIDTH  (DATA_WIDTH)
  ) u_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_vld_s1),
    .in_data   (b_dat_s1),
    .in_flag   (coll_s1),
    .out_valid (b_valid),
    .out_data  (b_dout),
    .out_flag  (collision)
  );

endmodule

// File: tb/tb_ram_dual_port_be.sv
// Directed bench: two instances share stimulus.
//   dut0: OUT_REG=1 (latency 2), read-first
//   dut1: OUT_REG=0 (latency 1), write-first
module tb_ram_dual_port_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_en = 1'b0;
  logic [3:0]  a_we = 4'h0;
  logic [3:0]  a_addr = 4'h0;
  logic [31:0] a_din = 32'h0;
  logic        b_en = 1'b0;
  logic [3:0]  b_addr = 4'h0;

  logic [31:0] a_dout0, b_dout0, a_dout1, b_dout1;
  logic        a_valid0, b_valid0, busy0, coll0;
  logic        a_valid1, b_valid1, busy1, coll1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_dual_port_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
    .OUT_REG(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout0), .a_valid(a_valid0),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout0), .b_valid(b_valid0),
    .busy(busy0), .collision(coll0)
  );

  ram_dual_port_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
    .OUT_REG(0), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout1), .a_valid(a_valid1),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout1), .b_valid(b_valid1),
    .busy(busy1), .collision(coll1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request cycle on either/both ports, then check both latencies.
  // ea0/ea1: port A read data expected from dut0 (read-first) / dut1 (write-first).
  task automatic access(input string tag,
                        input logic aon, input logic [3:0] we, input logic [3:0] aad,
                        input logic [31:0] din, input logic bon, input logic [3:0] bad_addr,
                        input logic [31:0] ea0, input logic [31:0] ea1,
                        input logic [31:0] eb, input logic ecol);
    a_en = aon; a_we = we; a_addr = aad; a_din = din;
    b_en = bon; b_addr = bad_addr;
    tick();
    a_en = 1'b0; a_we = 4'h0; b_en = 1'b0;
    chk({tag, ".a_valid1"}, {31'b0, a_valid1}, {31'b0, aon});
    if (aon) chk({tag, ".a_dout1"}, a_dout1, ea1);
    chk({tag, ".b_valid1"}, {31'b0, b_valid1}, {31'b0, bon});
    if (bon) chk({tag, ".b_dout1"}, b_dout1, eb);
    chk({tag, ".coll1"}, {31'b0, coll1}, {31'b0, ecol});
    chk({tag, ".a_valid0_early"}, {31'b0, a_valid0}, 32'h0);
    chk({tag, ".b_valid0_early"}, {31'b0, b_valid0}, 32'h0);
    tick();
    chk({tag, ".a_valid0"}, {31'b0, a_valid0}, {31'b0, aon});
    if (aon) chk({tag, ".a_dout0"}, a_dout0, ea0);
    chk({tag, ".b_valid0"}, {31'b0, b_valid0}, {31'b0, bon});
    if (bon) chk({tag, ".b_dout0"}, b_dout0, eb);
    chk({tag, ".coll0"}, {31'b0, coll0}, {31'b0, ecol});
    chk({tag, ".a_valid1_gone"}, {31'b0, a_valid1}, 32'h0);
    chk({tag, ".coll1_gone"}, {31'b0, coll1}, 32'h0);
  endtask

  // Counts busy cycles while hammering both ports; no valid may appear.
  task automatic count_clear(input string tag);
    int n;
    int pulses;
    n = 0;
    pulses = 0;
    a_en = 1'b1; a_we = 4'hF; a_addr = 4'h2; a_din = 32'hDEAD_BEEF;
    b_en = 1'b1; b_addr = 4'h2;
    while (busy0 && n < 100) begin
      tick();
      n++;
      if (a_valid0 || b_valid0 || a_valid1 || b_valid1) pulses++;
    end
    a_en = 1'b0; a_we = 4'h0; b_en = 1'b0;
    chk({tag, ".busy_cycles"}, n, 16);
    chk({tag, ".busy1"}, {31'b0, busy1}, 32'h0);
    chk({tag, ".masked_pulses"}, pulses, 0);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++)
      access(tag, 1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'(15 - i), 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst.busy0", {31'b0, busy0}, 32'h1);
    chk("rst.busy1", {31'b0, busy1}, 32'h1);
    chk("rst.a_dout0", a_dout0, 32'h0);
    chk("rst.b_dout1", b_dout1, 32'h0);
    chk("rst.valids", {28'b0, a_valid0, b_valid0, a_valid1, b_valid1}, 32'h0);
    chk("rst.coll", {30'b0, coll0, coll1}, 32'h0);

    // Clear after reset release
    rst = 1'b0;
    count_clear("clear");
    read_all_zero("zero1");

    // Byte enables
    access("be_full", 1'b1, 4'hF, 4'd5, 32'hAABB_CCDD, 1'b0, 4'd0,
           32'h0, 32'hAABB_CCDD, 32'h0, 1'b0);
    access("be_part", 1'b1, 4'b0101, 4'd5, 32'h1122_3344, 1'b0, 4'd0,
           32'hAABB_CCDD, 32'hAA22_CC44, 32'h0, 1'b0);
    access("be_read", 1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'd5,
           32'hAA22_CC44, 32'hAA22_CC44, 32'hAA22_CC44, 1'b0);

    // Read-during-write
    access("rdw_set", 1'b1, 4'hF, 4'd3, 32'h1, 1'b0, 4'd0, 32'h0, 32'h1, 32'h0, 1'b0);
    access("rdw", 1'b1, 4'hF, 4'd3, 32'h2, 1'b0, 4'd0, 32'h1, 32'h2, 32'h0, 1'b0);
    access("rdw_after", 1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'd0, 32'h2, 32'h2, 32'h0, 1'b0);

    // Collision
    access("col_set", 1'b1, 4'hF, 4'd7, 32'h55, 1'b0, 4'd0, 32'h0, 32'h55, 32'h0, 1'b0);
    access("col_hit", 1'b1, 4'hF, 4'd7, 32'h66, 1'b1, 4'd7, 32'h55, 32'h66, 32'h55, 1'b1);
    access("col_next", 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h0, 32'h0, 32'h66, 1'b0);
    access("col_rd_only", 1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'd7, 32'h66, 32'h66, 32'h66, 1'b0);
    access("col_diff", 1'b1, 4'hF, 4'd8, 32'h77, 1'b1, 4'd7, 32'h0, 32'h77, 32'h66, 1'b0);
    access("col_we0_en0", 1'b0, 4'hF, 4'd7, 32'h99, 1'b1, 4'd7, 32'h0, 32'h0, 32'h66, 1'b0);

    // Output hold: no request, dout keeps last value
    tick();
    chk("hold.b_dout0", b_dout0, 32'h66);
    chk("hold.b_dout1", b_dout1, 32'h66);
    chk("hold.a_dout1", a_dout1, 32'h77);

    // Reset mid-clear
    access("mid_fill", 1'b1, 4'hF, 4'd15, 32'hCAFE_F00D, 1'b0, 4'd0,
           32'h0, 32'hCAFE_F00D, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid.busy_at9", {31'b0, busy0}, 32'h1);
    rst = 1'b1;
    tick();
    tick();
    chk("mid.busy_in_rst", {31'b0, busy0}, 32'h1);
    rst = 1'b0;
    count_clear("mid_clear");
    read_all_zero("zero2");

    // Back-to-back B reads
    access("bb_w0", 1'b1, 4'hF, 4'd0, 32'h10, 1'b0, 4'd0, 32'h0, 32'h10, 32'h0, 1'b0);
    access("bb_w1", 1'b1, 4'hF, 4'd1, 32'h11, 1'b0, 4'd0, 32'h0, 32'h11, 32'h0, 1'b0);
    access("bb_w2", 1'b1, 4'hF, 4'd2, 32'h12, 1'b0, 4'd0, 32'h0, 32'h12, 32'h0, 1'b0);
    b_en = 1'b1; b_addr = 4'd0;
    tick();
    chk("bb.c1.v1", {31'b0, b_valid1}, 32'h1);
    chk("bb.c1.d1", b_dout1, 32'h10);
    chk("bb.c1.v0", {31'b0, b_valid0}, 32'h0);
    b_addr = 4'd1;
    tick();
    chk("bb.c2.v1", {31'b0, b_valid1}, 32'h1);
    chk("bb.c2.d1", b_dout1, 32'h11);
    chk("bb.c2.v0", {31'b0, b_valid0}, 32'h1);
    chk("bb.c2.d0", b_dout0, 32'h10);
    b_addr = 4'd2;
    tick();
    chk("bb.c3.v1", {31'b0, b_valid1}, 32'h1);
    chk("bb.c3.d1", b_dout1, 32'h12);
    chk("bb.c3.d0", b_dout0, 32'h11);
    b_en = 1'b0;
    tick();
    chk("bb.c4.v1", {31'b0, b_valid1}, 32'h0);
    chk("bb.c4.v0", {31'b0, b_valid0}, 32'h1);
    chk("bb.c4.d0", b_dout0, 32'h12);
    tick();
    chk("bb.c5.v0", {31'b0, b_valid0}, 32'h0);
    chk("bb.c5.hold1", b_dout1, 32'h12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_dual_port_be.md
Name: ram_dual_port_be

Overview:
Parametrised simple-dual-port RAM, the successor to the single-port asynchronous-read RAM.
- Port A: read/write, with per-byte write enables.
- Port B: read-only.
- Reads are synchronous, with an optional output register and per-port valid flags.
- Selectable read-during-write behaviour on port A, plus A-write/B-read collision detection.
- Optional hardware clear-after-reset state machine.
- Used as a scratchpad/buffer memory behind DMA and verification stimulus engines.

Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, write-enable granularity; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- OUT_REG, 1, 0 = read latency 1, 1 = read latency 2 (extra output register).
- RDW_MODE, 0, port A read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
- CLEAR_ON_RESET, 1, 1 = zero all words after reset release, 0 = contents undefined after reset.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, asynchronous active-high reset.
- a_en, input, 1, port A access request.
- a_we, input, NUM_BYTES, port A byte write enables; all-zero with a_en = read.
- a_addr, input, ADDR_WIDTH, port A address.
- a_din, input, DATA_WIDTH, port A write data.
- a_dout, output, DATA_WIDTH, port A read data.
- a_valid, output, 1, a_dout valid (one-cycle pulse per read).
- b_en, input, 1, port B read request.
- b_addr, input, ADDR_WIDTH, port B address.
- b_dout, output, DATA_WIDTH, port B read data.
- b_valid, output, 1, b_dout valid.
- busy, output, 1, clear in progress; requests are ignored while high.
- collision, output, 1, A-write/B-read same-address event, aligned with b_valid.

Behaviour:
- **Reset** (asynchronous on rst=1):
  - a_dout, b_dout = 0; a_valid, b_valid, collision = 0.
  - busy = CLEAR_ON_RESET; FSM enters CLEAR (if CLEAR_ON_RESET) else READY.
  - Array contents are not reset by rst itself.
- **FSM states:** CLEAR, READY.
- **CLEAR:**
  - Clear counter starts at 0 and writes all-zero to mem[cnt] each cycle, cnt increments.
  - At cnt = DEPTH-1 the write completes; next state is READY and busy drops. Total DEPTH cycles after reset release.
  - a_en and b_en are masked: no reads, no writes, no valid pulses.
- **Reset mid-CLEAR:** the counter returns to 0 and the clear restarts from the beginning after release.
- **READY:** a_en and b_en are serviced every cycle; no backpressure; one access per port per cycle.
- **Port A write:**
  - When a_en=1, for each byte i with a_we[i]=1: mem[a_addr] byte i <= a_din byte i.
  - Other bytes are unchanged.
- **Port A read:**
  - Any a_en=1 cycle, including writes, produces a read.
  - The read reaches a_dout with a_valid=1 exactly 1+OUT_REG cycles after the request.
  - With RDW_MODE=0, a_dout holds the pre-write word.
  - With RDW_MODE=1, a_dout holds the merged post-write word.
- **Port B read:**
  - A b_en=1 request reaches b_dout with b_valid=1 exactly 1+OUT_REG cycles later.
- **Collision:**
  - Condition: a_en=1, a_we≠0, b_en=1, a_addr==b_addr in the same cycle.
  - b_dout returns the old word regardless of RDW_MODE.
  - collision=1 in the same cycle as the corresponding b_valid.
- **Output hold:** a_dout and b_dout hold their last value when valid=0; the valid flags are not sticky.
- **Pipeline:** valid and collision pipelines advance every cycle and are independent per port.
- **Addressing:** addresses are always in range (full 2**ADDR_WIDTH decode); there is no wrap logic beyond the natural address width.

Decomposition:
- Package ram_pkg:
  - FSM state enum (CLEAR, READY).
  - Function computing NUM_BYTES.
  - RDW_MODE encoding constants (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1).
- Sub-module ram_out_pipe: parametrised depth-0/1 data+valid(+flag) register stage.
  - Instantiated once per port.
  - Port B instance carries the collision bit.
- The top holds the array, byte-merge logic, clear FSM/counter and collision compare.

Test Plan:
- **Clear:** ADDR_WIDTH=4, CLEAR_ON_RESET=1. Release rst, count cycles.
  - busy=1 for exactly 16 cycles, then 0.
  - Reads of addresses 0..15 all return 0x00000000.
  - Requests issued while busy yield no valid pulse.
- **Byte-enable write:**
  - Write 0xAABBCCDD to addr 5 with a_we=4'b1111.
  - Then write 0x11223344 to addr 5 with a_we=4'b0101.
  - A read of addr 5 returns 0xAA22CC44 with a_valid exactly 2 cycles after the request (OUT_REG=1).
- **Read-during-write:**
  - Set mem[3]=0x1, then in one cycle a_en=1, a_we=4'hF, a_din=0x2 at addr 3.
  - RDW_MODE=0: a_dout=0x1. RDW_MODE=1: a_dout=0x2.
- **Collision:**
  - mem[7]=0x55. Same cycle: A writes 0x66 to addr 7, B reads addr 7.
  - b_dout=0x55, b_valid=1 and collision=1 together; the next B read of addr 7 returns 0x66 with collision=0.
- **Reset mid-clear:**
  - Assert rst at clear cycle 9, release after 2 cycles.
  - busy stays high for a full 16 further cycles and every word reads 0.
- **Back-to-back B reads** (OUT_REG=0):
  - Addresses 0,1,2 on consecutive cycles, after writing 0x10,0x11,0x12.
  - b_valid is high for 3 consecutive cycles with b_dout = 0x10, 0x11, 0x12, one cycle after each request.
